// File: rtl/keypad_pkg.sv
// Shared types, widths and column-decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned NUM_W = 16;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned ROW_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  // Active columns in one row sample, saturated: 0, 1, or 2 meaning "two or more".
  function automatic logic [1:0] col_hits(input logic [COLS-1:0] cols_n);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < int'(COLS); i++) n = n + 3'(~cols_n[i]);
    return (n > 3'd1) ? 2'd2 : 2'(n);
  endfunction

  // Index of the lowest active column; only meaningful when exactly one is active.
  function automatic logic [1:0] col_index(input logic [COLS-1:0] cols_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = int'(COLS) - 1; i >= 0; i--) if (!cols_n[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_sync2.sv
// Two-flop synchronizer for the asynchronous column sense lines; idles high like the pull-ups.
module sync2
  import keypad_pkg::*;
#(
  parameter int unsigned W = COLS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: row scan, frame classification with ghost rejection,
// press/release debounce FSM and a 16-bit digit entry shift register.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV_BITS   = 16,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ROWS-1:0]  row_n,
  input  logic [COLS-1:0]  col_n,
  input  logic             clear,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_held,
  output logic [NUM_W-1:0] num
);

  logic [COLS-1:0]          col_s;
  logic [SCAN_DIV_BITS-1:0] div_q;
  logic [ROW_W-1:0]         row_idx_q, row_idx_d;
  logic [ROWS-1:0]          row_n_q;
  logic [1:0]               acc_hits_q, acc_hits_d;
  logic [KEY_W-1:0]         acc_code_q, acc_code_d;
  logic [1:0]               row_hits, sum_hits;
  logic [2:0]               hit_sum;
  logic [KEY_W-1:0]         frame_code;
  logic                     tick, frame_end, frame_single;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d, cnt_inc;
  logic                     cnt_done, same_code;
  logic [KEY_W-1:0]         cand_q, cand_d;
  logic [KEY_W-1:0]         key_q, key_d;
  logic                     key_valid_q, key_valid_d;
  logic                     key_held_q;
  logic [NUM_W-1:0]         num_q, num_d;

  sync2 #(.W(COLS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (col_n),
    .q_o (col_s)
  );

  assign tick      = &div_q;
  assign frame_end = tick && (row_idx_q == 2'(ROWS - 1));

  // Accumulate contacts over the four row samples of a frame.
  always_comb begin
    row_hits   = col_hits(col_s);
    hit_sum    = 3'(acc_hits_q) + 3'(row_hits);
    sum_hits   = (hit_sum > 3'd1) ? 2'd2 : 2'(hit_sum);
    frame_code = (row_hits == 2'd1) ? {row_idx_q, col_index(col_s)} : acc_code_q;
    row_idx_d  = tick ? row_idx_q + 2'd1 : row_idx_q;
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (tick) begin
      acc_hits_d = frame_end ? 2'd0 : sum_hits;
      acc_code_d = frame_end ? '0 : frame_code;
    end
  end

  assign frame_single = frame_end && (sum_hits == 2'd1);
  assign cnt_inc      = cnt_q + 4'd1;
  assign cnt_done     = (cnt_inc == 4'(DEBOUNCE_FRAMES));
  assign same_code    = (frame_code == cand_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      row_idx_q   <= '0;
      row_n_q     <= '1;
      acc_hits_q  <= '0;
      acc_code_q  <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      num_q       <= '0;
    end else begin
      div_q       <= div_q + SCAN_DIV_BITS'(1);
      row_idx_q   <= row_idx_d;
      row_n_q     <= ~(ROWS'(1) << row_idx_d);
      acc_hits_q  <= acc_hits_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= (state_d == HELD) || (state_d == RELEASE);
      num_q       <= num_d;
    end
  end

  // Next state: evaluated only at frame end; MULTI frames count as NONE.
  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      case (state_q)
        IDLE:     if (frame_single) state_d = DEBOUNCE;
        DEBOUNCE: begin
          if (!frame_single)              state_d = IDLE;
          else if (same_code && cnt_done) state_d = HELD;
        end
        HELD:     if (!frame_single) state_d = RELEASE;
        RELEASE: begin
          if (frame_single)  state_d = HELD;
          else if (cnt_done) state_d = IDLE;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // Datapath updates: candidate tracking, frame counter, key strobe and entry shift.
  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_single) begin
            cand_d = frame_code;
            cnt_d  = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (frame_single && same_code) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              key_d       = cand_q;
              key_valid_d = 1'b1;
            end
          end else if (frame_single) begin
            cand_d = frame_code;
            cnt_d  = 4'd1;
          end
        end
        HELD:    if (!frame_single) cnt_d = 4'd1;
        RELEASE: if (!frame_single) cnt_d = cnt_inc;
        default: ;
      endcase
    end
    num_d = num_q;
    if (clear)            num_d = '0;
    else if (key_valid_d) num_d = {num_q[NUM_W-KEY_W-1:0], cand_q};
  end

  assign row_n     = row_n_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign num       = num_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Scoreboard bench for keypad_scan_4x4 with P=16 (frame = 64 clocks) and 3-frame debounce.
module tb_keypad_scan_4x4;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] num;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        clear;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] num;

  logic [15:0] pressed;
  logic [15:0] exp_num;
  exp_t        exp_q[$];
  int          cyc;
  int          checks;
  int          errors;

  keypad_scan_4x4 #(.SCAN_DIV_BITS(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .clear     (clear),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .num       (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Keypad matrix: a pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every key_valid cycle must match the oldest expected acceptance.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key_valid: got key 0x%0h num 0x%0h expected no pulse (cycle %0d)",
                 key, num, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_key", 32'(key), 32'(e.key));
        check("sb_num", 32'(num), 32'(e.num));
        check("sb_held", 32'(key_held), 32'd1);
        if (e.cyc >= 0) check("sb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic frames(input int n);
    repeat (64 * n) @(negedge clk);
  endtask

  task automatic held_frames(input int n, input logic exp);
    for (int i = 0; i < n; i++) begin
      frames(1);
      check("key_held_frame", 32'(key_held), 32'(exp));
    end
  endtask

  task automatic push_exp(input logic [3:0] k, input int c);
    exp_t e;
    exp_num = {exp_num[11:0], k};
    e.key = k;
    e.num = exp_num;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic press_accept(input logic [3:0] k);
    pressed = 16'(1) << k;
    push_exp(k, cyc + 192);
    frames(3);
    check("held_after_accept", 32'(key_held), 32'd1);
  endtask

  task automatic release_all();
    pressed = '0;
    frames(3);
    check("held_after_release", 32'(key_held), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    exp_num = '0;
    clear   = 1'b0;
    rst     = 1'b1;
    pressed = 16'(1) << 6;
    repeat (3) @(negedge clk);
    check("reset_row_n", 32'(row_n), 32'hF);
    check("reset_key", 32'(key), 32'h0);
    check("reset_key_valid", 32'(key_valid), 32'h0);
    check("reset_key_held", 32'(key_held), 32'h0);
    check("reset_num", 32'(num), 32'h0);

    // Clean press of 0x6 held from reset release: accepted at clock 192.
    push_exp(4'h6, 192);
    rst = 1'b0;
    @(negedge clk);
    check("first_row_n", 32'(row_n), 32'hE);
    repeat (191) @(negedge clk);
    check("clean_held", 32'(key_held), 32'd1);
    frames(1);
    pressed = '0;
    repeat (191) @(negedge clk);
    check("held_before_fall", 32'(key_held), 32'd1);
    @(negedge clk);
    check("held_fall_at_448", 32'(key_held), 32'd0);

    // Digit entry 1..5.
    for (int k = 1; k <= 5; k++) begin
      press_accept(4'(k));
      release_all();
    end
    check("entry_num", 32'(num), 32'h2345);

    // Bounce on 0xA, then steady.
    for (int i = 0; i < 2; i++) begin
      pressed = 16'(1) << 10;
      frames(1);
      pressed = '0;
      frames(1);
    end
    check("bounce_no_held", 32'(key_held), 32'd0);
    press_accept(4'hA);
    release_all();

    // Ghost 0x3 + 0xC, then 0x3 alone, then extra keys while held.
    pressed = (16'(1) << 3) | (16'(1) << 12);
    held_frames(4, 1'b0);
    press_accept(4'h3);
    pressed = (16'(1) << 3) | (16'(1) << 12);
    held_frames(2, 1'b1);
    pressed = 16'(1) << 3;
    held_frames(1, 1'b1);
    pressed = 16'(1) << 12;
    held_frames(2, 1'b1);
    check("held_key_kept", 32'(key), 32'h3);
    release_all();

    // Short release of 0x5.
    press_accept(4'h5);
    held_frames(1, 1'b1);
    pressed = '0;
    held_frames(1, 1'b1);
    pressed = 16'(1) << 5;
    held_frames(2, 1'b1);
    release_all();
    check("num_before_clear", 32'(num), 32'h5A35);

    // Clear on the accepting cycle of 0x7.
    begin
      exp_t e;
      pressed = 16'(1) << 7;
      exp_num = '0;
      e.key = 4'h7;
      e.num = 16'h0000;
      e.cyc = cyc + 192;
      exp_q.push_back(e);
      repeat (191) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_num", 32'(num), 32'h0);
      check("clear_key", 32'(key), 32'h7);
    end
    release_all();
    press_accept(4'h1);
    release_all();

    // Reset in the middle of debouncing 0x9.
    pressed = 16'(1) << 9;
    frames(2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_row_n", 32'(row_n), 32'hF);
    check("midrst_key", 32'(key), 32'h0);
    check("midrst_key_valid", 32'(key_valid), 32'h0);
    check("midrst_key_held", 32'(key_held), 32'h0);
    check("midrst_num", 32'(num), 32'h0);
    exp_num = '0;
    push_exp(4'h9, 192);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_first_row_n", 32'(row_n), 32'hE);
    repeat (191) @(negedge clk);
    check("post_rst_key", 32'(key), 32'h9);
    release_all();

    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
